// File: rtl/riscv_ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle, with pipeline stall request and flush.
module riscv_ex_muldiv #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [XLEN-1:0]     alu_a_i,
    input  logic [XLEN-1:0]     alu_b_i,
    input  logic                flush_i,
    output logic [XLEN-1:0]     result_o,
    output logic                valid_o,
    output logic                stall_req_o,
    output logic                busy_o
);

    // M-extension opcode values, kept in step with riscv_define.v
    localparam logic [ALU_OP_W-1:0] ALU_MUL    = ALU_OP_W'('h10);
    localparam logic [ALU_OP_W-1:0] ALU_MULH   = ALU_OP_W'('h11);
    localparam logic [ALU_OP_W-1:0] ALU_MULHSU = ALU_OP_W'('h12);
    localparam logic [ALU_OP_W-1:0] ALU_MULHU  = ALU_OP_W'('h13);
    localparam logic [ALU_OP_W-1:0] ALU_DIV    = ALU_OP_W'('h14);
    localparam logic [ALU_OP_W-1:0] ALU_DIVU   = ALU_OP_W'('h15);
    localparam logic [ALU_OP_W-1:0] ALU_REM    = ALU_OP_W'('h16);
    localparam logic [ALU_OP_W-1:0] ALU_REMU   = ALU_OP_W'('h17);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [2:0] {
        K_MUL, K_MULH, K_MULHSU, K_MULHU, K_DIV, K_DIVU, K_REM, K_REMU
    } kind_t;

    state_t             r_state;
    kind_t              r_kind;
    logic [CNT_W-1:0]   r_count;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opnd;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [XLEN-1:0]    r_result;

    logic               w_md_op;
    kind_t              w_kind;
    logic               w_is_div;
    logic               w_is_rem;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div0;
    logic               w_ovf;
    logic [XLEN-1:0]    w_special_res;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_md_op = 1'b1;
        w_kind  = K_MUL;
        case (alu_op_i)
            ALU_MUL:    w_kind = K_MUL;
            ALU_MULH:   w_kind = K_MULH;
            ALU_MULHSU: w_kind = K_MULHSU;
            ALU_MULHU:  w_kind = K_MULHU;
            ALU_DIV:    w_kind = K_DIV;
            ALU_DIVU:   w_kind = K_DIVU;
            ALU_REM:    w_kind = K_REM;
            ALU_REMU:   w_kind = K_REMU;
            default:    w_md_op = 1'b0;
        endcase
    end

    assign w_is_div = w_kind inside {K_DIV, K_DIVU, K_REM, K_REMU};
    assign w_is_rem = w_kind inside {K_REM, K_REMU};
    assign w_sign_a = (w_kind inside {K_MULH, K_MULHSU, K_DIV, K_REM}) & alu_a_i[XLEN-1];
    assign w_sign_b = (w_kind inside {K_MULH, K_DIV, K_REM}) & alu_b_i[XLEN-1];
    assign w_mag_a  = w_sign_a ? -alu_a_i : alu_a_i;
    assign w_mag_b  = w_sign_b ? -alu_b_i : alu_b_i;

    // Divide-by-zero and signed overflow bypass the iteration entirely
    assign w_div0 = w_is_div && (alu_b_i == '0);
    assign w_ovf  = (w_kind inside {K_DIV, K_REM}) && (alu_a_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (alu_b_i == '1);

    always_comb begin
        w_special_res = '0;
        if (w_div0)
            w_special_res = w_is_rem ? alu_a_i : '1;
        else if (!w_is_rem)
            w_special_res = {1'b1, {(XLEN-1){1'b0}}};
    end

    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_mul_next;
    logic [XLEN:0]      w_div_hi;
    logic [XLEN:0]      w_div_diff;
    logic [2*XLEN-1:0]  w_div_next;
    logic [2*XLEN-1:0]  w_acc_next;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_final;

    // Multiply: {partial_hi, multiplier}, add multiplicand on LSB then shift right
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: {rem, quo}; trial-subtract on the 33-bit shifted remainder
    assign w_div_hi   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_hi - {1'b0, r_opnd};
    assign w_div_next = w_div_diff[XLEN] ? {w_div_hi[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_acc_next = (r_kind inside {K_DIV, K_DIVU, K_REM, K_REMU}) ? w_div_next : w_mul_next;
    assign w_prod     = r_neg_q ? -w_acc_next : w_acc_next;
    assign w_quo      = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem      = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        case (r_kind)
            K_MUL:                      w_final = w_prod[XLEN-1:0];
            K_MULH, K_MULHSU, K_MULHU:  w_final = w_prod[2*XLEN-1:XLEN];
            K_DIV, K_DIVU:              w_final = w_quo;
            default:                    w_final = w_rem;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_kind   <= K_MUL;
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_md_op) begin
                        r_kind  <= w_kind;
                        r_neg_q <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= S_DONE;
                        end else begin
                            r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
                            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                            r_count <= '0;
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(XLEN - 1)) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flush must drop stall and suppress the strobe within the same cycle
    assign result_o    = r_result;
    assign valid_o     = (r_state == S_DONE) && !flush_i;
    assign busy_o      = (r_state == S_BUSY);
    assign stall_req_o = !flush_i && (((r_state == S_IDLE) && w_md_op) || (r_state == S_BUSY));

endmodule
